// File: rtl/memory_nr_1w_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_nr_1w_pkg
// Description : Shared types and helpers for the multi-read, single-write
//               scratchpad: fabric word width, host read FSM states and the
//               address-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_nr_1w_pkg;

   localparam int TIA_WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      HOST_IDLE    = 2'd0,
      HOST_CAPTURE = 2'd1,
      HOST_ACK     = 2'd2
   } host_state_t;

   // Number of index bits needed to address a bank of the given depth.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/memory_nr_1w_if.sv
`default_nettype none
// ============================================================================
// Module      : link_if / mmio_if
// Description : Valid/ack word link used by the processing-element channels,
//               and the memory-mapped host read/write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface link_if;
   import memory_nr_1w_pkg::*;

   logic                      valid;
   logic [TIA_WORD_WIDTH-1:0] data;
   logic                      ack;

   modport sender   (output valid, output data, input  ack);
   modport receiver (input  valid, input  data, output ack);
endinterface

interface mmio_if;
   import memory_nr_1w_pkg::*;

   logic                      read_req;
   logic [TIA_WORD_WIDTH-1:0] read_index;
   logic [TIA_WORD_WIDTH-1:0] read_data;
   logic                      read_ack;
   logic                      write_req;
   logic [TIA_WORD_WIDTH-1:0] write_index;
   logic [TIA_WORD_WIDTH-1:0] write_data;
   logic                      write_ack;

   modport host (
      output read_req, output read_index, input read_data, input read_ack,
      output write_req, output write_index, output write_data, input write_ack
   );
   modport device (
      input read_req, input read_index, output read_data, output read_ack,
      input write_req, input write_index, input write_data, output write_ack
   );
endinterface
`default_nettype wire

// File: rtl/memory_nr_1w_read_lane.sv
`default_nettype none
// ============================================================================
// Module      : memory_read_lane
// Description : One read lane: a private RAM bank (written in lockstep with all
//               other banks), issue/capture/output registers, and the optional
//               same-cycle write forwarding compare.
//               Optional feature macro: MEMORY_WRITE_FORWARD_EN
// Revision    : 1.0 - initial release
// ============================================================================
module memory_read_lane
   import memory_nr_1w_pkg::*;
#(
   parameter  int DEPTH      = 1024,
   localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      host_read,
   input  logic [ADDR_WIDTH-1:0]     host_addr,
   input  logic                      write_en,
   input  logic [ADDR_WIDTH-1:0]     write_addr,
   input  logic [TIA_WORD_WIDTH-1:0] write_data,
   link_if.receiver                  index_link,
   link_if.sender                    data_link,
   output logic [TIA_WORD_WIDTH-1:0] bank_data,
   output logic                      busy,
   output logic                      stalled
);

   logic [TIA_WORD_WIDTH-1:0] ram [DEPTH];
   logic [ADDR_WIDTH-1:0]     read_addr;
   logic [ADDR_WIDTH-1:0]     ram_addr;
   logic                      ram_read;
   logic                      inflight;
   logic                      out_valid;
   logic [TIA_WORD_WIDTH-1:0] out_data;
   logic [TIA_WORD_WIDTH-1:0] capture_data;
   logic                      drain;
   logic                      issue;
   logic                      capture;
   logic                      unused_index_bits;

   assign read_addr         = index_link.data[ADDR_WIDTH-1:0];
   assign unused_index_bits = ^index_link.data[TIA_WORD_WIDTH-1:ADDR_WIDTH];

   // The output register only hands data over while the lane is enabled.
   assign drain   = enable && out_valid && data_link.ack;
   // A finished read is sitting in the bank output with nowhere to go; the
   // bank output must not be overwritten until it is captured.
   assign stalled = inflight && out_valid && !drain;
   assign issue   = enable && index_link.valid && !host_read && !stalled;
   assign capture = enable && inflight && (!out_valid || drain);

   assign ram_read = issue || host_read;
   assign ram_addr = host_read ? host_addr : read_addr;

   // Bank write port: every lane's copy receives the same write stream.
   always_ff @(posedge clock) begin
      if (write_en) begin
         ram[write_addr] <= write_data;
      end
   end

   // Bank read port: registered output, held until the next read.
   always_ff @(posedge clock) begin
      if (ram_read) begin
         bank_data <= ram[ram_addr];
      end
   end

`ifdef MEMORY_WRITE_FORWARD_EN
   logic                      fwd_hit;
   logic [TIA_WORD_WIDTH-1:0] fwd_data;

   // Remember whether the issuing read collided with the write of that cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fwd_hit  <= 1'b0;
         fwd_data <= '0;
      end else if (issue) begin
         fwd_hit  <= write_en && (write_addr == read_addr);
         fwd_data <= write_data;
      end
   end

   assign capture_data = fwd_hit ? fwd_data : bank_data;
`else
   assign capture_data = bank_data;
`endif

   // Issue / capture / output bookkeeping for this lane.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         inflight  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (issue) begin
            inflight <= 1'b1;
         end else if (capture) begin
            inflight <= 1'b0;
         end
         if (capture) begin
            out_valid <= 1'b1;
            out_data  <= capture_data;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign index_link.ack = issue;
   assign data_link.valid = enable && out_valid;
   assign data_link.data  = out_data;
   assign busy            = inflight || out_valid;

endmodule
`default_nettype wire

// File: rtl/memory_nr_1w.sv
`default_nettype none
// ============================================================================
// Module      : memory_nr_1w
// Description : Multi-read, single-write scratchpad. One RAM bank per PE read
//               port, all written in lockstep; host MMIO port with write
//               priority and a bank-0 read FSM; registered quiescent flag.
//               Optional feature macro: MEMORY_WRITE_FORWARD_EN
// Revision    : 1.0 - initial release
// ============================================================================
module memory_nr_1w
   import memory_nr_1w_pkg::*;
#(
   parameter int NUM_READ_PORTS = 4,
   parameter int DEPTH          = 1024
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     enable,
   mmio_if.device   host_interface,
   link_if.receiver read_index_input_links [NUM_READ_PORTS],
   link_if.sender   read_data_output_links [NUM_READ_PORTS],
   link_if.receiver write_index_input_link,
   link_if.receiver write_data_input_link,
   output logic     quiescent
);

   localparam int ADDR_WIDTH = addr_width(DEPTH);

   logic                      pe_write;
   logic                      write_en;
   logic [ADDR_WIDTH-1:0]     write_addr;
   logic [TIA_WORD_WIDTH-1:0] write_data;
   logic [ADDR_WIDTH-1:0]     host_read_addr;

   host_state_t               host_state;
   host_state_t               host_state_next;
   logic                      host_issue;
   logic                      host_capture;
   logic [TIA_WORD_WIDTH-1:0] host_data;
   logic [TIA_WORD_WIDTH-1:0] host_capture_data;

   logic [NUM_READ_PORTS-1:0] lane_busy;
   logic [NUM_READ_PORTS-1:0] index_valid;
   logic [TIA_WORD_WIDTH-1:0] bank0_data;
   logic                      lane0_stalled;
   logic                      unused_index_bits;

   assign unused_index_bits = ^{host_interface.read_index[TIA_WORD_WIDTH-1:ADDR_WIDTH],
                                host_interface.write_index[TIA_WORD_WIDTH-1:ADDR_WIDTH],
                                write_index_input_link.data[TIA_WORD_WIDTH-1:ADDR_WIDTH]};

   // Write mux: host writes ignore enable and pre-empt the PE write links.
   assign pe_write   = enable && write_index_input_link.valid &&
                       write_data_input_link.valid && !host_interface.write_req;
   assign write_en   = host_interface.write_req || pe_write;
   assign write_addr = host_interface.write_req ?
                       host_interface.write_index[ADDR_WIDTH-1:0] :
                       write_index_input_link.data[ADDR_WIDTH-1:0];
   assign write_data = host_interface.write_req ?
                       host_interface.write_data : write_data_input_link.data;

   assign host_interface.write_ack = host_interface.write_req;
   assign write_index_input_link.ack = pe_write;
   assign write_data_input_link.ack  = pe_write;

   assign host_read_addr = host_interface.read_index[ADDR_WIDTH-1:0];

   // Host read FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         host_state <= HOST_IDLE;
      end else begin
         host_state <= host_state_next;
      end
   end

   // Host read FSM next state; a stalled lane-0 result defers the host read
   // so that the shared bank output is never overwritten before capture.
   always_comb begin
      host_state_next = host_state;
      host_issue      = 1'b0;
      host_capture    = 1'b0;
      if (enable) begin
         case (host_state)
            HOST_IDLE: begin
               if (host_interface.read_req && !lane0_stalled) begin
                  host_issue      = 1'b1;
                  host_state_next = HOST_CAPTURE;
               end
            end
            HOST_CAPTURE: begin
               host_capture    = 1'b1;
               host_state_next = HOST_ACK;
            end
            HOST_ACK: begin
               if (!host_interface.read_req) begin
                  host_state_next = HOST_IDLE;
               end
            end
            default: host_state_next = HOST_IDLE;
         endcase
      end
   end

`ifdef MEMORY_WRITE_FORWARD_EN
   logic                      host_fwd_hit;
   logic [TIA_WORD_WIDTH-1:0] host_fwd_data;

   // Remember whether the host read collided with the write of its issue cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         host_fwd_hit  <= 1'b0;
         host_fwd_data <= '0;
      end else if (host_issue) begin
         host_fwd_hit  <= write_en && (write_addr == host_read_addr);
         host_fwd_data <= write_data;
      end
   end

   assign host_capture_data = host_fwd_hit ? host_fwd_data : bank0_data;
`else
   assign host_capture_data = bank0_data;
`endif

   // Host read data register, loaded one cycle after the bank-0 read.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         host_data <= '0;
      end else if (host_capture) begin
         host_data <= host_capture_data;
      end
   end

   assign host_interface.read_ack  = (host_state == HOST_ACK);
   assign host_interface.read_data = host_data;

   // One lane per read port; lane 0 also serves the host read path.
   for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_lane
      assign index_valid[g] = read_index_input_links[g].valid;
      if (g == 0) begin : g_host_port
         memory_read_lane #(.DEPTH(DEPTH)) u_lane (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable),
            .host_read  (host_issue),
            .host_addr  (host_read_addr),
            .write_en   (write_en),
            .write_addr (write_addr),
            .write_data (write_data),
            .index_link (read_index_input_links[g]),
            .data_link  (read_data_output_links[g]),
            .bank_data  (bank0_data),
            .busy       (lane_busy[g]),
            .stalled    (lane0_stalled)
         );
      end else begin : g_pe_port
         logic [TIA_WORD_WIDTH-1:0] unused_bank_data;
         logic                      unused_stalled;
         memory_read_lane #(.DEPTH(DEPTH)) u_lane (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable),
            .host_read  (1'b0),
            .host_addr  ('0),
            .write_en   (write_en),
            .write_addr (write_addr),
            .write_data (write_data),
            .index_link (read_index_input_links[g]),
            .data_link  (read_data_output_links[g]),
            .bank_data  (unused_bank_data),
            .busy       (lane_busy[g]),
            .stalled    (unused_stalled)
         );
      end
   end

   // Quiescent: nothing held in any lane and no request waiting on any link.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         quiescent <= 1'b0;
      end else if (enable) begin
         quiescent <= !(|lane_busy) && !(|index_valid) &&
                      !write_index_input_link.valid && !write_data_input_link.valid;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_memory_nr_1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_nr_1w
// Description : Self-checking bench for memory_nr_1w (4 ports, depth 16).
//               Reference memory array plus per-port expected-data queues.
//               Optional feature macro: MEMORY_WRITE_FORWARD_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_nr_1w;
   import memory_nr_1w_pkg::*;

   localparam int N     = 4;
   localparam int DEPTH = 16;
   localparam int W     = TIA_WORD_WIDTH;

   typedef logic [W-1:0] word_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic quiescent;

   always #5 clock = ~clock;

   mmio_if host_bus ();
   link_if rd_idx [N] ();
   link_if rd_dat [N] ();
   link_if wr_idx ();
   link_if wr_dat ();

   logic [N-1:0] iv, ia, ov, oa;
   word_t        iaddr [N];
   word_t        odata [N];
   logic         wv, dv, wia, wda;
   word_t        widx_d, wdata_d;

   for (genvar g = 0; g < N; g++) begin : g_port
      assign rd_idx[g].valid = iv[g];
      assign rd_idx[g].data  = iaddr[g];
      assign ia[g]           = rd_idx[g].ack;
      assign ov[g]           = rd_dat[g].valid;
      assign odata[g]        = rd_dat[g].data;
      assign rd_dat[g].ack   = oa[g];
   end

   assign wr_idx.valid = wv;
   assign wr_idx.data  = widx_d;
   assign wr_dat.valid = dv;
   assign wr_dat.data  = wdata_d;
   assign wia          = wr_idx.ack;
   assign wda          = wr_dat.ack;

   memory_nr_1w #(.NUM_READ_PORTS(N), .DEPTH(DEPTH)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .enable                 (enable),
      .host_interface         (host_bus),
      .read_index_input_links (rd_idx),
      .read_data_output_links (rd_dat),
      .write_index_input_link (wr_idx),
      .write_data_input_link  (wr_dat),
      .quiescent              (quiescent)
   );

   int    passed = 0;
   int    total  = 0;
   word_t model_mem [DEPTH];
   word_t exp_q [N][$];

   task automatic check(input string name, input word_t act, input word_t exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Reference model and scoreboard: everything observed here completes at
   // the coming rising edge.
   always @(negedge clock) begin
      logic  pe_pred;
      logic  wen;
      int    waddr;
      word_t wdata;
      int    a;
      word_t e;
      if (reset) begin
         pe_pred = enable && wv && dv && !host_bus.write_req;
         if (wv || dv || host_bus.write_req)
            check("pe_write_ack", {30'd0, wia, wda}, {30'd0, pe_pred, pe_pred});
         wen   = host_bus.write_req || pe_pred;
         waddr = host_bus.write_req ? int'(host_bus.write_index % DEPTH) : int'(widx_d % DEPTH);
         wdata = host_bus.write_req ? host_bus.write_data : wdata_d;
         for (int p = 0; p < N; p++) begin
            if (ov[p] && oa[p]) begin
               if (exp_q[p].size() == 0) check($sformatf("port%0d_unexpected", p), 1, 0);
               else check($sformatf("port%0d_data", p), odata[p], exp_q[p].pop_front());
            end
         end
         for (int p = 0; p < N; p++) begin
            if (ia[p]) begin
               a = int'(iaddr[p] % DEPTH);
               e = model_mem[a];
`ifdef MEMORY_WRITE_FORWARD_EN
               if (wen && waddr == a) e = wdata;
`endif
               exp_q[p].push_back(e);
            end
         end
         if (wen) model_mem[waddr] = wdata;
      end
   end

   task automatic host_write(input int a, input word_t d);
      host_bus.write_req   = 1'b1;
      host_bus.write_index = word_t'(a);
      host_bus.write_data  = d;
      #1;
      check("host_write_ack", {31'd0, host_bus.write_ack}, 1);
      tick();
      host_bus.write_req = 1'b0;
   endtask

   initial begin
      int    cnt;
      word_t hexp;
      iv = '0; oa = '1; wv = 0; dv = 0; widx_d = '0; wdata_d = '0;
      for (int p = 0; p < N; p++) iaddr[p] = '0;
      host_bus.read_req = 0; host_bus.read_index = '0;
      host_bus.write_req = 0; host_bus.write_index = '0; host_bus.write_data = '0;
      enable = 1'b1;
      tick(3);
      check("rst_out_valid", {28'd0, ov}, 0);
      check("rst_read_ack", {31'd0, host_bus.read_ack}, 0);
      check("rst_quiescent", {31'd0, quiescent}, 0);
      reset = 1'b1;
      tick(2);
      check("idle_quiescent", {31'd0, quiescent}, 1);

      for (int a = 0; a < DEPTH; a++) host_write(a, $urandom);

      // Broadcast read of a host-written word.
      host_write(3, 32'hA5);
      iv = '1;
      for (int p = 0; p < N; p++) iaddr[p] = 3;
      #1;
      check("broadcast_ack", {28'd0, ia}, 32'hF);
      tick();
      iv = '0;
      check("broadcast_t1_valid", {28'd0, ov}, 0);
      tick();
      check("broadcast_t2_valid", {28'd0, ov}, 32'hF);
      for (int p = 0; p < N; p++) check("broadcast_data", odata[p], 32'hA5);
      tick();

      // Port 1 streams 0..7 without bubbles.
      for (int i = 0; i < 8; i++) begin
         iv[1] = 1'b1; iaddr[1] = word_t'(i);
         #1;
         check("stream_ack", {31'd0, ia[1]}, 1);
         if (i >= 2) check("stream_valid", {31'd0, ov[1]}, 1);
         tick();
      end
      iv[1] = 1'b0;
      check("stream_tail6", {31'd0, ov[1]}, 1);
      tick();
      check("stream_tail7", {31'd0, ov[1]}, 1);
      tick();
      check("stream_end", {31'd0, ov[1]}, 0);

      // Port 2 back-pressure.
      oa[2] = 1'b0; iv[2] = 1'b1; iaddr[2] = 9; cnt = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (ia[2]) cnt++;
         tick();
      end
      check("backpressure_accepts", word_t'(cnt), 2);
      check("backpressure_hold", {31'd0, ov[2]}, 1);
      iv[2] = 1'b0; oa[2] = 1'b1;
      tick(4);

      // Host read of addr 5 while port 0 streams.
      for (int c = 0; c < 8; c++) begin
         iv[0] = 1'b1; iaddr[0] = $urandom_range(63);
         if (c == 2) begin
            host_bus.read_req = 1'b1; host_bus.read_index = 5;
            hexp = model_mem[5];
         end
         #1;
         check("lane0_issue", {31'd0, ia[0]}, (c == 2) ? 0 : 1);
         if (c == 3) check("host_ack_t1", {31'd0, host_bus.read_ack}, 0);
         if (c == 4) begin
            check("host_ack_t2", {31'd0, host_bus.read_ack}, 1);
            check("host_read_data", host_bus.read_data, hexp);
            host_bus.read_req = 1'b0;
         end
         if (c == 5) check("host_ack_drop", {31'd0, host_bus.read_ack}, 0);
         tick();
      end
      iv[0] = 1'b0;
      tick(3);

      // Host and PE write collide; PE address 20 wraps to 4.
      wv = 1; widx_d = 20; dv = 1; wdata_d = 32'h11;
      host_bus.write_req = 1; host_bus.write_index = 4; host_bus.write_data = 32'h22;
      #1;
      check("collide_pe_ack", {30'd0, wia, wda}, 0);
      check("collide_host_ack", {31'd0, host_bus.write_ack}, 1);
      tick();
      host_bus.write_req = 0;
      iv[3] = 1'b1; iaddr[3] = 4;
      #1;
      check("late_pe_ack", {30'd0, wia, wda}, 3);
      tick();
      wv = 0; dv = 0;
      tick();
      iv[3] = 1'b0;
`ifdef MEMORY_WRITE_FORWARD_EN
      check("wrap_read_same_cycle", odata[3], 32'h11);
`else
      check("wrap_read_same_cycle", odata[3], 32'h22);
`endif
      tick();
      check("wrap_read_after", odata[3], 32'h11);
      tick(2);

      // Same-cycle read and write of addr 7.
      host_write(7, 32'h1);
      wv = 1; widx_d = 7; dv = 1; wdata_d = 32'h2;
      iv[0] = 1'b1; iaddr[0] = 7;
      tick();
      wv = 0; dv = 0; iv[0] = 1'b0;
      tick();
      check("collision_valid", {31'd0, ov[0]}, 1);
`ifdef MEMORY_WRITE_FORWARD_EN
      check("collision_data", odata[0], 32'h2);
`else
      check("collision_data", odata[0], 32'h1);
`endif
      tick(2);

      // Randomised traffic.
      for (int c = 0; c < 400; c++) begin
         enable = ($urandom_range(7) != 0);
         iv = 4'($urandom); oa = 4'($urandom);
         for (int p = 0; p < N; p++) iaddr[p] = $urandom_range(63);
         wv = 1'($urandom); dv = 1'($urandom);
         widx_d = $urandom_range(63); wdata_d = $urandom;
         host_bus.write_req = ($urandom_range(7) == 0);
         host_bus.write_index = $urandom_range(63);
         host_bus.write_data = $urandom;
         tick();
      end
      enable = 1'b1; iv = '0; oa = '1; wv = 0; dv = 0; host_bus.write_req = 0;
      for (int c = 0; c < 50; c++) begin
         if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
         tick();
      end
      for (int p = 0; p < N; p++) check("random_drained", word_t'(exp_q[p].size()), 0);

      // Reset in the middle of streaming with a host read acknowledged.
      iv = '1;
      for (int p = 0; p < N; p++) iaddr[p] = $urandom_range(15);
      host_bus.read_req = 1'b1; host_bus.read_index = 2;
      tick(2);
      check("pre_reset_read_ack", {31'd0, host_bus.read_ack}, 1);
      #2;
      reset = 1'b0;
      iv = '0; host_bus.read_req = 1'b0;
      #1;
      check("midrst_out_valid", {28'd0, ov}, 0);
      check("midrst_read_ack", {31'd0, host_bus.read_ack}, 0);
      check("midrst_quiescent", {31'd0, quiescent}, 0);
      for (int p = 0; p < N; p++) exp_q[p].delete();
      tick(2);
      reset = 1'b1;
      tick(2);
      check("post_reset_quiescent", {31'd0, quiescent}, 1);
      iv[1] = 1'b1; iaddr[1] = 2;
      tick();
      iv[1] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (exp_q[1].size() == 0) break;
         tick();
      end
      check("post_reset_drained", word_t'(exp_q[1].size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
